// File: rtl/lzrw1_pkg.sv
// Shared types and format constants for the LZRW1 group packer.
// The group size is fixed by the LZRW1 format (16-bit control word).
package lzrw1_pkg;

    localparam int unsigned GROUP_ITEMS = 16;
    localparam int unsigned OFFSET_W    = 12;
    localparam int unsigned LEN_W       = 4;
    localparam int unsigned IDX_W       = $clog2(GROUP_ITEMS);
    localparam int unsigned CNT_W       = $clog2(GROUP_ITEMS + 1);

    typedef struct packed {
        logic                ctrl;
        logic [7:0]          literal;
        logic [OFFSET_W-1:0] offset;
        logic [LEN_W-1:0]    length;
    } item_t;

    typedef enum logic [2:0] {
        COLLECT,
        CTRL_LO,
        CTRL_HI,
        ITEMS,
        DONE
    } pack_state_e;

endpackage

// File: rtl/lzrw1_item_buffer.sv
// Register file holding one LZRW1 group of items plus its control-bit vector.
// Cleared as a whole when the group has been fully serialised.
module lzrw1_item_buffer
    import lzrw1_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wrEn,
    input  logic [IDX_W-1:0]       wrIdx,
    input  item_t                  wrItem,
    input  logic                   clear,
    input  logic [IDX_W-1:0]       rdIdx,
    output item_t                  rdItem,
    output logic [GROUP_ITEMS-1:0] ctrlBits
);

    item_t slots [GROUP_ITEMS];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < GROUP_ITEMS; i++) begin
                slots[i] <= '0;
            end
        end else if (clear) begin
            // Zeroing every slot keeps ctrl bits of absent items at 0 for the next partial group.
            for (int unsigned i = 0; i < GROUP_ITEMS; i++) begin
                slots[i] <= '0;
            end
        end else if (wrEn) begin
            slots[wrIdx] <= wrItem;
        end
    end

    assign rdItem = slots[rdIdx];

    always_comb begin
        ctrlBits = '0;
        for (int unsigned i = 0; i < GROUP_ITEMS; i++) begin
            ctrlBits[i] = slots[i].ctrl;
        end
    end

endmodule

// File: rtl/lzrw1_group_packer.sv
// Collects literal/copy items into LZRW1 groups and serialises each group
// (control word low byte first, then item bytes) over a valid/ready byte stream.
module lzrw1_group_packer
    import lzrw1_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                tok_valid,
    output logic                tok_ready,
    input  logic                tok_ctrl,
    input  logic [7:0]          tok_literal,
    input  logic [OFFSET_W-1:0] tok_offset,
    input  logic [LEN_W-1:0]    tok_length,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_byte,
    output logic                out_last,
    output logic                done
);

    pack_state_e state, stateNext;

    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       countNext;
    logic [IDX_W-1:0]       emitPtr;
    logic                   subByte;
    logic                   lastFlag;
    logic                   flushPending;
    logic                   emptyDone;
    logic                   accept;
    logic                   flushNow;
    logic                   outFire;
    logic                   slotEnd;
    logic                   groupEnd;
    logic                   clearBuf;
    item_t                  wrItem;
    item_t                  rdItem;
    logic [GROUP_ITEMS-1:0] ctrlBits;

    assign accept    = (state == COLLECT) && tok_valid;
    assign countNext = count + CNT_W'(accept);
    assign flushNow  = (state == COLLECT) && (flush || flushPending);
    assign outFire   = out_valid && out_ready;
    assign slotEnd   = !rdItem.ctrl || subByte;
    assign groupEnd  = (state == ITEMS) && slotEnd && ({1'b0, emitPtr} == count - CNT_W'(1));
    assign clearBuf  = outFire && groupEnd;

    assign wrItem.ctrl    = tok_ctrl;
    assign wrItem.literal = tok_literal;
    assign wrItem.offset  = tok_offset;
    assign wrItem.length  = tok_length;

    lzrw1_item_buffer u_buffer (
        .clock    (clock),
        .reset    (reset),
        .wrEn     (accept),
        .wrIdx    (count[IDX_W-1:0]),
        .wrItem   (wrItem),
        .clear    (clearBuf),
        .rdIdx    (emitPtr),
        .rdItem   (rdItem),
        .ctrlBits (ctrlBits)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            COLLECT: begin
                if (countNext == CNT_W'(GROUP_ITEMS) || (flushNow && countNext != '0)) begin
                    stateNext = CTRL_LO;
                end
            end
            CTRL_LO: if (outFire) stateNext = CTRL_HI;
            CTRL_HI: if (outFire) stateNext = ITEMS;
            ITEMS: begin
                if (outFire && groupEnd) begin
                    stateNext = lastFlag ? DONE : COLLECT;
                end
            end
            DONE:    stateNext = COLLECT;
            default: stateNext = COLLECT;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            emitPtr      <= '0;
            subByte      <= 1'b0;
            lastFlag     <= 1'b0;
            flushPending <= 1'b0;
            emptyDone    <= 1'b0;
        end else begin
            emptyDone <= flushNow && (countNext == '0);
            if (state != COLLECT && flush) begin
                flushPending <= 1'b1;
            end
            unique case (state)
                COLLECT: begin
                    count   <= countNext;
                    emitPtr <= '0;
                    subByte <= 1'b0;
                    // An item arriving with flush is captured first, so the flush closes a group that includes it.
                    if (flushNow) begin
                        flushPending <= 1'b0;
                        if (countNext != '0) begin
                            lastFlag <= 1'b1;
                        end
                    end
                end
                ITEMS: begin
                    if (outFire) begin
                        if (slotEnd) begin
                            subByte <= 1'b0;
                            emitPtr <= emitPtr + IDX_W'(1);
                        end else begin
                            subByte <= 1'b1;
                        end
                        if (groupEnd) begin
                            count    <= '0;
                            lastFlag <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    count    <= '0;
                    lastFlag <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tok_ready = (state == COLLECT);
        out_valid = 1'b0;
        out_byte  = '0;
        out_last  = 1'b0;
        done      = (state == DONE) || emptyDone;
        unique case (state)
            CTRL_LO: begin
                out_valid = 1'b1;
                out_byte  = ctrlBits[7:0];
            end
            CTRL_HI: begin
                out_valid = 1'b1;
                out_byte  = ctrlBits[15:8];
            end
            ITEMS: begin
                out_valid = 1'b1;
                if (!rdItem.ctrl) begin
                    out_byte = rdItem.literal;
                end else if (!subByte) begin
                    out_byte = {rdItem.length, rdItem.offset[OFFSET_W-1:8]};
                end else begin
                    out_byte = rdItem.offset[7:0];
                end
                out_last = lastFlag && groupEnd;
            end
            default: ;
        endcase
    end

endmodule
